// File: rtl/mux_share_arbiter.sv
// Round-robin arbiter that time-shares a 2:1 multiplexor between two requesters,
// with a per-grant burst limit and a registered valid/ready output stage.
module mux_share_arbiter #(
  parameter int WIDTH     = 5,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] in0,
  input  logic             req1,
  input  logic [WIDTH-1:0] in1,
  input  logic             out_ready,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic [WIDTH-1:0] mux_out,
  output logic             out_valid,
  output logic             busy
);

  localparam int CW = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t        state;
  logic          last;
  logic [CW-1:0] beat_cnt;

  logic slot_free;
  logic accept0;
  logic accept1;
  logic burst_end;
  logic release0;
  logic release1;

  assign gnt0 = (state == GRANT0);
  assign gnt1 = (state == GRANT1);
  assign sel  = (state == GRANT1);
  assign busy = (state != IDLE);

  // Output handshake: a beat transfers downstream on any clock edge where
  // out_valid && out_ready; mux_out/out_valid never change while out_valid && !out_ready.
  assign slot_free = !out_valid || out_ready;
  assign accept0   = gnt0 && req0 && slot_free;
  assign accept1   = gnt1 && req1 && slot_free;
  assign burst_end = (beat_cnt == LAST_BEAT);
  assign release0  = gnt0 && (!req0 || (accept0 && burst_end));
  assign release1  = gnt1 && (!req1 || (accept1 && burst_end));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      beat_cnt  <= '0;
      mux_out   <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept0 || accept1) begin
        mux_out   <= accept1 ? in1 : in0;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (req0 && req1) state <= last ? GRANT0 : GRANT1;
          else if (req0)    state <= GRANT0;
          else if (req1)    state <= GRANT1;
        end
        GRANT0: begin
          if (release0) begin
            last     <= 1'b0;
            beat_cnt <= '0;
            // The other side goes first; otherwise re-grant with no idle bubble.
            if (req1)      state <= GRANT1;
            else if (req0) state <= GRANT0;
            else           state <= IDLE;
          end else if (accept0) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        GRANT1: begin
          if (release1) begin
            last     <= 1'b1;
            beat_cnt <= '0;
            if (req0)      state <= GRANT0;
            else if (req1) state <= GRANT1;
            else           state <= IDLE;
          end else if (accept1) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
